// File: rtl/butterfly_r2_cfg.sv
// Radix-2 complex butterfly with run-time DIT/DIF, inverse and scaling controls.
// Four-stage pipeline with rounding, output saturation and a sticky overflow flag.
module butterfly_r2_cfg #(
  parameter int DW   = 16,
  parameter int TW   = 16,
  parameter int FRAC = 13,
  parameter int OW   = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 EN,
  input  logic                 IN_VALID,
  input  logic                 MODE,
  input  logic                 INV,
  input  logic                 SCALE,
  input  logic signed [DW-1:0] XP_R,
  input  logic signed [DW-1:0] XP_I,
  input  logic signed [DW-1:0] XQ_R,
  input  logic signed [DW-1:0] XQ_I,
  input  logic signed [TW-1:0] TF_R,
  input  logic signed [TW-1:0] TF_I,
  input  logic                 OVF_CLR,
  output logic                 OUT_VALID,
  output logic signed [OW-1:0] YP_R,
  output logic signed [OW-1:0] YP_I,
  output logic signed [OW-1:0] YQ_R,
  output logic signed [OW-1:0] YQ_I,
  output logic                 OVF
);

  // One internal width wide enough for every product, sum and rounding step.
  localparam int PW = DW + TW + 4;
  localparam logic signed [PW-1:0] RND  = PW'(1) <<< (FRAC - 1);
  localparam logic signed [PW-1:0] OMAX = (PW'(1) <<< (OW - 1)) - PW'(1);
  localparam logic signed [PW-1:0] OMIN = -(PW'(1) <<< (OW - 1));

  function automatic logic signed [PW-1:0] round_frac(input logic signed [PW-1:0] x);
    return (x + RND) >>> FRAC;
  endfunction

  // Stage 1: inputs, controls and the (optionally conjugated) twiddle; one extra
  // twiddle bit so negating the most negative value cannot wrap.
  logic                 s1_v_reg, s1_mode_reg, s1_scale_reg;
  logic signed [DW-1:0] s1_p_r_reg, s1_p_i_reg, s1_q_r_reg, s1_q_i_reg;
  logic signed [TW:0]   s1_w_r_reg, s1_w_i_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_v_reg     <= 1'b0;
      s1_mode_reg  <= 1'b0;
      s1_scale_reg <= 1'b0;
      s1_p_r_reg   <= '0;
      s1_p_i_reg   <= '0;
      s1_q_r_reg   <= '0;
      s1_q_i_reg   <= '0;
      s1_w_r_reg   <= '0;
      s1_w_i_reg   <= '0;
    end else if (EN) begin
      s1_v_reg     <= IN_VALID;
      s1_mode_reg  <= MODE;
      s1_scale_reg <= SCALE;
      s1_p_r_reg   <= XP_R;
      s1_p_i_reg   <= XP_I;
      s1_q_r_reg   <= XQ_R;
      s1_q_i_reg   <= XQ_I;
      s1_w_r_reg   <= (TW+1)'(TF_R);
      s1_w_i_reg   <= INV ? -((TW+1)'(TF_I)) : (TW+1)'(TF_I);
    end
  end

  // Stage 2: DIT partial products of Q*W', DIF sum and difference.
  logic                 s2_v_reg, s2_mode_reg, s2_scale_reg;
  logic signed [PW-1:0] s2_p_r_reg, s2_p_i_reg, s2_w_r_reg, s2_w_i_reg;
  logic signed [PW-1:0] s2_pp_rr_reg, s2_pp_ii_reg, s2_pp_ri_reg, s2_pp_ir_reg;
  logic signed [PW-1:0] s2_sum_r_reg, s2_sum_i_reg, s2_dif_r_reg, s2_dif_i_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s2_v_reg     <= 1'b0;
      s2_mode_reg  <= 1'b0;
      s2_scale_reg <= 1'b0;
      s2_p_r_reg   <= '0;
      s2_p_i_reg   <= '0;
      s2_w_r_reg   <= '0;
      s2_w_i_reg   <= '0;
      s2_pp_rr_reg <= '0;
      s2_pp_ii_reg <= '0;
      s2_pp_ri_reg <= '0;
      s2_pp_ir_reg <= '0;
      s2_sum_r_reg <= '0;
      s2_sum_i_reg <= '0;
      s2_dif_r_reg <= '0;
      s2_dif_i_reg <= '0;
    end else if (EN) begin
      s2_v_reg     <= s1_v_reg;
      s2_mode_reg  <= s1_mode_reg;
      s2_scale_reg <= s1_scale_reg;
      s2_p_r_reg   <= PW'(s1_p_r_reg);
      s2_p_i_reg   <= PW'(s1_p_i_reg);
      s2_w_r_reg   <= PW'(s1_w_r_reg);
      s2_w_i_reg   <= PW'(s1_w_i_reg);
      s2_pp_rr_reg <= PW'(s1_q_r_reg) * PW'(s1_w_r_reg);
      s2_pp_ii_reg <= PW'(s1_q_i_reg) * PW'(s1_w_i_reg);
      s2_pp_ri_reg <= PW'(s1_q_r_reg) * PW'(s1_w_i_reg);
      s2_pp_ir_reg <= PW'(s1_q_i_reg) * PW'(s1_w_r_reg);
      s2_sum_r_reg <= PW'(s1_p_r_reg) + PW'(s1_q_r_reg);
      s2_sum_i_reg <= PW'(s1_p_i_reg) + PW'(s1_q_i_reg);
      s2_dif_r_reg <= PW'(s1_p_r_reg) - PW'(s1_q_r_reg);
      s2_dif_i_reg <= PW'(s1_p_i_reg) - PW'(s1_q_i_reg);
    end
  end

  // Stage 3: DIT rounds M; DIF forms the partial products of (P-Q)*W'.
  logic                 s3_v_reg, s3_mode_reg, s3_scale_reg;
  logic signed [PW-1:0] s3_p_r_reg, s3_p_i_reg, s3_m_r_reg, s3_m_i_reg;
  logic signed [PW-1:0] s3_sum_r_reg, s3_sum_i_reg;
  logic signed [PW-1:0] s3_dpp_rr_reg, s3_dpp_ii_reg, s3_dpp_ri_reg, s3_dpp_ir_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s3_v_reg      <= 1'b0;
      s3_mode_reg   <= 1'b0;
      s3_scale_reg  <= 1'b0;
      s3_p_r_reg    <= '0;
      s3_p_i_reg    <= '0;
      s3_m_r_reg    <= '0;
      s3_m_i_reg    <= '0;
      s3_sum_r_reg  <= '0;
      s3_sum_i_reg  <= '0;
      s3_dpp_rr_reg <= '0;
      s3_dpp_ii_reg <= '0;
      s3_dpp_ri_reg <= '0;
      s3_dpp_ir_reg <= '0;
    end else if (EN) begin
      s3_v_reg      <= s2_v_reg;
      s3_mode_reg   <= s2_mode_reg;
      s3_scale_reg  <= s2_scale_reg;
      s3_p_r_reg    <= s2_p_r_reg;
      s3_p_i_reg    <= s2_p_i_reg;
      s3_m_r_reg    <= round_frac(s2_pp_rr_reg - s2_pp_ii_reg);
      s3_m_i_reg    <= round_frac(s2_pp_ri_reg + s2_pp_ir_reg);
      s3_sum_r_reg  <= s2_sum_r_reg;
      s3_sum_i_reg  <= s2_sum_i_reg;
      s3_dpp_rr_reg <= s2_dif_r_reg * s2_w_r_reg;
      s3_dpp_ii_reg <= s2_dif_i_reg * s2_w_i_reg;
      s3_dpp_ri_reg <= s2_dif_r_reg * s2_w_i_reg;
      s3_dpp_ir_reg <= s2_dif_i_reg * s2_w_r_reg;
    end
  end

  // Stage 4: final combine, optional halving, saturation. Order: yp_r, yp_i, yq_r, yq_i.
  logic signed [PW-1:0] pre_next    [4];
  logic signed [PW-1:0] scaled_next [4];
  logic signed [OW-1:0] sat_next    [4];
  logic [3:0]           clip_next;

  always_comb begin
    pre_next[0] = s3_p_r_reg + s3_m_r_reg;
    pre_next[1] = s3_p_i_reg + s3_m_i_reg;
    pre_next[2] = s3_p_r_reg - s3_m_r_reg;
    pre_next[3] = s3_p_i_reg - s3_m_i_reg;
    if (s3_mode_reg) begin
      pre_next[0] = s3_sum_r_reg;
      pre_next[1] = s3_sum_i_reg;
      pre_next[2] = round_frac(s3_dpp_rr_reg - s3_dpp_ii_reg);
      pre_next[3] = round_frac(s3_dpp_ri_reg + s3_dpp_ir_reg);
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sat
      assign scaled_next[gi] = s3_scale_reg ? (pre_next[gi] + PW'(1)) >>> 1 : pre_next[gi];
      assign clip_next[gi]   = (scaled_next[gi] > OMAX) || (scaled_next[gi] < OMIN);
      assign sat_next[gi]    = (scaled_next[gi] > OMAX) ? OW'(OMAX) :
                               (scaled_next[gi] < OMIN) ? OW'(OMIN) : OW'(scaled_next[gi]);
    end
  endgenerate

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OUT_VALID <= 1'b0;
      YP_R      <= '0;
      YP_I      <= '0;
      YQ_R      <= '0;
      YQ_I      <= '0;
      OVF       <= 1'b0;
    end else if (EN) begin
      OUT_VALID <= s3_v_reg;
      YP_R      <= sat_next[0];
      YP_I      <= sat_next[1];
      YQ_R      <= sat_next[2];
      YQ_I      <= sat_next[3];
      // A clamp on a valid sample beats a simultaneous clear.
      if (s3_v_reg && (|clip_next))
        OVF <= 1'b1;
      else if (OVF_CLR)
        OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_butterfly_r2_cfg.sv
// Directed self-checking bench for butterfly_r2_cfg: modes, inverse, scaling,
// saturation, sticky overflow, stall, streaming and asynchronous reset.
module tb_butterfly_r2_cfg;

  logic               CLK = 1'b0;
  logic               RESET, EN, IN_VALID, MODE, INV, SCALE, OVF_CLR;
  logic signed [15:0] XP_R, XP_I, XQ_R, XQ_I, TF_R, TF_I;
  logic               OUT_VALID, OVF;
  logic signed [15:0] YP_R, YP_I, YQ_R, YQ_I;

  int checks = 0;
  int errors = 0;

  butterfly_r2_cfg #(.DW(16), .TW(16), .FRAC(13), .OW(16)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .IN_VALID(IN_VALID), .MODE(MODE),
    .INV(INV), .SCALE(SCALE), .XP_R(XP_R), .XP_I(XP_I), .XQ_R(XQ_R), .XQ_I(XQ_I),
    .TF_R(TF_R), .TF_I(TF_I), .OVF_CLR(OVF_CLR), .OUT_VALID(OUT_VALID),
    .YP_R(YP_R), .YP_I(YP_I), .YQ_R(YQ_R), .YQ_I(YQ_I), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic i, input logic s,
                       input int pr, input int pi, input int qr, input int qi,
                       input int wr, input int wi);
    IN_VALID = v; MODE = m; INV = i; SCALE = s;
    XP_R = pr[15:0]; XP_I = pi[15:0]; XQ_R = qr[15:0]; XQ_I = qi[15:0];
    TF_R = wr[15:0]; TF_I = wi[15:0];
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_y(input string tag, input int v, input int ypr, input int ypi,
                       input int yqr, input int yqi);
    $display("txn %s: valid=%0d yp=(%0d,%0d) yq=(%0d,%0d) ovf=%0d",
             tag, OUT_VALID, YP_R, YP_I, YQ_R, YQ_I, OVF);
    check({tag, ".valid"}, OUT_VALID, v);
    check({tag, ".yp_r"}, YP_R, ypr);
    check({tag, ".yp_i"}, YP_I, ypi);
    check({tag, ".yq_r"}, YQ_R, yqr);
    check({tag, ".yq_i"}, YQ_I, yqi);
  endtask

  // Stream sample k: P=(10k,-k), Q=(k,2k), W=-j; odd k use DIF, even k DIT.
  function automatic int s_ypr(input int k); return (k % 2) ? 11*k : 12*k; endfunction
  function automatic int s_ypi(input int k); return (k % 2) ? k : -2*k;    endfunction
  function automatic int s_yqr(input int k); return (k % 2) ? -3*k : 8*k;  endfunction
  function automatic int s_yqi(input int k); return (k % 2) ? -9*k : 0;    endfunction

  initial begin
    RESET = 1'b1; EN = 1'b0; OVF_CLR = 1'b0;
    idle();
    step(); step();
    chk_y("reset", 0, 0, 0, 0, 0);
    check("reset.ovf", OVF, 0);
    RESET = 1'b0; EN = 1'b1;

    // DIT unity, DIT -j forward, DIT -j inverse, DIF -j back to back.
    drive(1, 0, 0, 0, 100, 50, 20, -10, 8192, 0);  step();
    drive(1, 0, 0, 0, 100, 50, 20, -10, 0, -8192); step();
    drive(1, 0, 1, 0, 100, 50, 20, -10, 0, -8192); step();
    drive(1, 1, 0, 0, 100, 50, 20, -10, 0, -8192); step();
    chk_y("dit_unity", 1, 120, 40, 80, 60);
    check("dit_unity.ovf", OVF, 0);
    idle(); step();
    chk_y("dit_fwd", 1, 90, 30, 110, 70);
    step();
    chk_y("dit_inv", 1, 110, 70, 90, 30);
    step();
    chk_y("dif", 1, 120, 40, 60, -80);
    step();
    check("bubble.valid", OUT_VALID, 0);

    // Positive and negative saturation, sticky OVF.
    drive(1, 0, 0, 0, 32767, -32768, 32767, -32768, 8192, 0); step();
    idle(); step(); step(); step();
    chk_y("sat", 1, 32767, -32768, 0, 0);
    check("sat.ovf", OVF, 1);
    step(); step();
    check("sat.ovf_sticky", OVF, 1);
    OVF_CLR = 1'b1; step(); OVF_CLR = 1'b0;
    check("ovf_clr", OVF, 0);

    // Same sample halved: exact fit, no clamp; then rounding of -3.
    drive(1, 0, 0, 1, 32767, -32768, 32767, -32768, 8192, 0); step();
    drive(1, 0, 0, 1, -3, 0, 0, 0, 8192, 0); step();
    idle(); step(); step();
    chk_y("scaled", 1, 32767, -32768, 0, 0);
    check("scaled.ovf", OVF, 0);
    step();
    chk_y("round_m3", 1, -1, 0, -1, 0);

    // A clamping sample that is not valid must not set OVF.
    drive(0, 0, 0, 0, 32767, 0, 32767, 0, 8192, 0); step();
    idle(); step(); step(); step();
    chk_y("invalid_sat", 0, 32767, 0, 0, 0);
    check("invalid_sat.ovf", OVF, 0);

    // Clamp coinciding with OVF_CLR: set wins.
    drive(1, 0, 0, 0, 32767, 0, 32767, 0, 8192, 0); step();
    idle(); step(); step();
    OVF_CLR = 1'b1; step(); OVF_CLR = 1'b0;
    check("set_wins.ovf", OVF, 1);
    OVF_CLR = 1'b1; step(); OVF_CLR = 1'b0;
    check("set_wins.clr", OVF, 0);

    // Eight back-to-back samples with alternating mode and a 3-cycle stall.
    for (int n = 0; n < 13; n++) begin
      if (n < 8) drive(1, ((n + 1) % 2) == 1, 0, 0, 10*(n+1), -(n+1), n+1, 2*(n+1), 0, -8192);
      else idle();
      if (n == 5) begin
        EN = 1'b0;
        for (int c = 0; c < 3; c++) begin
          step();
          chk_y($sformatf("stall%0d", c), 1, s_ypr(2), s_ypi(2), s_yqr(2), s_yqi(2));
        end
        EN = 1'b1;
      end
      step();
      if (n >= 3) begin
        if (n - 2 <= 8)
          chk_y($sformatf("stream%0d", n - 2), 1, s_ypr(n-2), s_ypi(n-2), s_yqr(n-2), s_yqi(n-2));
        else
          check($sformatf("stream_tail%0d", n), OUT_VALID, 0);
      end
    end
    check("stream.ovf", OVF, 0);

    // Asynchronous reset with three samples in flight.
    drive(1, 0, 0, 0, 32767, 0, 32767, 0, 8192, 0); step();
    drive(1, 0, 0, 0, 100, 50, 20, -10, 8192, 0); step(); step(); step();
    chk_y("pre_reset", 1, 32767, 0, 0, 0);
    check("pre_reset.ovf", OVF, 1);
    #2 RESET = 1'b1;
    #1;
    chk_y("async_reset", 0, 0, 0, 0, 0);
    check("async_reset.ovf", OVF, 0);
    idle();
    #2 RESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("post_reset%0d.valid", c), OUT_VALID, 0);
    end
    drive(1, 0, 0, 0, 100, 50, 20, -10, 8192, 0); step();
    idle(); step(); step(); step();
    chk_y("post_reset_sample", 1, 120, 40, 80, 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/butterfly_r2_cfg.md
# butterfly_r2_cfg

Parametrised radix-2 complex butterfly for the FFT datapath: one complex pair (P, Q) and one twiddle W per cycle, a fixed 4-cycle pipeline, and a result pair per cycle. Run-time controls select DIT or DIF ordering, forward or inverse transform (conjugated twiddle), and optional divide-by-2 scaling. Outputs are rounded and saturated to a configurable width with a sticky overflow flag. The block sits between the stage memory read ports and the write-back path of each FFT stage.

## Interface
- DW, 16: signed width of the P and Q components.
- TW, 16: signed width of the twiddle components.
- FRAC, 13: fraction bits of the twiddle; 1.0 = 2^FRAC.
- OW, 16: signed width of the output components.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- EN  in  1  pipeline clock enable; 0 freezes every register, including valid bits and OVF.
- IN_VALID  in  1  input sample is valid this cycle.
- MODE  in  1  0 = DIT, 1 = DIF.
- INV  in  1  1 = use the conjugate of W.
- SCALE  in  1  1 = halve the results with rounding.
- XP_R, XP_I, XQ_R, XQ_I  in  DW each  inputs P and Q.
- TF_R, TF_I  in  TW each  twiddle W.
- OVF_CLR  in  1  synchronous clear of OVF; takes effect only when EN = 1.
- OUT_VALID  out  1  output sample is valid.
- YP_R, YP_I, YQ_R, YQ_I  out  OW each  outputs.
- OVF  out  1  sticky saturation flag.

## Operation
- MODE, INV and SCALE are captured with the data in stage 1 and travel with the sample, so a per-sample mode change is legal.
- W' = conj(W) when INV = 1, otherwise W.
- Complex multiply:
  - re = (ar*br − ai*bi), im = (ar*bi + ai*br), computed at full width.
  - Each result is rounded half-up to FRAC fraction bits: add 2^(FRAC−1), then arithmetic shift right by FRAC.
- DIT: M = round(Q·W'); Yp = P + M; Yq = P − M.
- DIF: Yp = P + Q; Yq = round((P − Q)·W'). The difference is DW+1 bits wide and enters the multiplier at that width.
- Scaling: with SCALE = 1, each component becomes (x + 1) >>> 1. With SCALE = 0 the value is unchanged.
- Saturation: values above 2^(OW−1)−1 clamp to 2^(OW−1)−1; values below −2^(OW−1) clamp to −2^(OW−1).
- OVF behaviour:
  - OVF is set in the cycle that any component of a valid output sample clamps.
  - OVF stays set until reset, or until OVF_CLR = 1 with EN = 1.
  - If a clamp and OVF_CLR occur in the same cycle, set wins.
- Samples with IN_VALID = 0 still propagate through the datapath, but they never set OVF.

## Timing
- Pipeline stages, one stage per EN = 1 cycle, latency 4:
  - S1: register inputs and controls; conjugate the twiddle.
  - S2: DIT forms the four partial products; DIF forms P±Q.
  - S3: DIT combines and rounds M; DIF forms the partial products of (P−Q)·W'.
  - S4: add/sub (DIT) or combine and round (DIF), then scale, saturate and register the outputs.
- OUT_VALID equals IN_VALID delayed by 4 EN-qualified cycles. Throughput is 1 sample per enabled cycle, with no bubbles.
- EN = 0 holds every register and output stable. Stalls of any length are lossless.
- Reset:
  - Effective immediately: all pipeline registers, OUT_VALID, all Y outputs and OVF go to 0.
  - Samples in flight are discarded.
  - The first valid output after reset is released appears 4 enabled cycles after its IN_VALID.
- Both modes have identical latency. Switching mode between consecutive samples causes no hazard or gap.

## Test plan
- DIT unity twiddle: MODE=0, P=(100,50), Q=(20,−10), W=(8192,0), SCALE=0 -> after 4 cycles OUT_VALID=1, Yp=(120,40), Yq=(80,60), OVF=0.
- DIT twiddle −j, forward and inverse: same P and Q, W=(0,−8192).
  - INV=0 -> Yp=(90,30), Yq=(110,70).
  - INV=1 on the next cycle -> Yp=(110,70), Yq=(90,30), one cycle later.
- DIF: MODE=1, P=(100,50), Q=(20,−10), W=(0,−8192) -> Yp=(120,40), Yq=(60,−80).
- Saturation and scaling: P=(32767,0), Q=(32767,0), W=(8192,0).
  - SCALE=0 -> Yp_R=32767, OVF=1.
  - OVF stays 1 over later samples until OVF_CLR is pulsed with EN=1.
  - Same sample with SCALE=1 -> Yp_R=32767 exact and OVF not set.
  - Rounding check: SCALE=1 on a result of −3 -> −1.
- Stall and streaming: 8 back-to-back valid samples, EN=0 for 3 cycles mid-stream -> outputs held unchanged during the stall; all 8 results emerge in order, exactly 4 enabled cycles after their inputs.
- Reset mid-operation: assert RESET asynchronously with 3 samples in flight -> OUT_VALID, Y outputs and OVF go to 0 at once, without waiting for a clock edge; no stale sample appears after release.
